// File: rtl/lr_consistency_check_pkg.sv
// Shared defaults for the left-right consistency stage.
// Disparity words are unsigned fixed point; integer part = d >> LR_FRAC.
package sgm_lr_pkg;

    localparam int LR_WIDTH   = 16;
    localparam int LR_FRAC    = 4;
    localparam int LR_DMAX    = 128;
    localparam int LR_INVALID = 0;
    localparam int COL_W      = 11;

    typedef logic [COL_W-1:0] col_t;

endpackage

// File: rtl/lr_consistency_check_if.sv
// Pixel-pair stream in, checked disparity stream out.
// master = upstream filter side, slave = consistency checker.
interface lr_consistency_check_if #(
    parameter int WIDTH = sgm_lr_pkg::LR_WIDTH
);
    logic             valid_in;
    logic [WIDTH-1:0] disp_L;
    logic [WIDTH-1:0] disp_R;
    logic [WIDTH-1:0] disp_out;
    logic             reject;
    logic             valid_out;

    modport master (
        output valid_in, disp_L, disp_R,
        input  disp_out, reject, valid_out
    );

    modport slave (
        input  valid_in, disp_L, disp_R,
        output disp_out, reject, valid_out
    );
endinterface

// File: rtl/lr_consistency_check_history.sv
// Purpose: right-disparity history of the previous DMAX-1 columns plus idx select mux.
// Latency: select is combinational; history shifts on the enabled edge.
// Backpressure: none; shift_en freezes the whole history when low.
module lr_disp_history
    import sgm_lr_pkg::*;
#(
    parameter int WIDTH = LR_WIDTH,
    parameter int FRAC  = LR_FRAC,
    parameter int DMAX  = LR_DMAX,
    parameter int IDX_W = WIDTH - FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] disp_R,
    input  logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] dR_sel
);

    // hist[k] is the right disparity from k columns ago, so idx maps straight onto it.
    logic [WIDTH-1:0] hist [1:DMAX-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 1; k < DMAX; k++) begin
                hist[k] <= '0;
            end
        end else if (shift_en) begin
            hist[1] <= disp_R;
            for (int k = 2; k < DMAX; k++) begin
                hist[k] <= hist[k-1];
            end
        end
    end

    always_comb begin
        dR_sel = '0;
        if (idx == '0) begin
            dR_sel = disp_R;
        end else begin
            for (int k = 1; k < DMAX; k++) begin
                if (idx == IDX_W'(k)) begin
                    dR_sel = hist[k];
                end
            end
        end
    end

endmodule

// File: rtl/lr_consistency_check.sv
// Purpose: left-right disparity consistency check; rejects occluded/mismatched pixels.
// Latency: 2 enabled cycles from accepted beat to valid_out, 1 pixel/cycle.
// Backpressure: none; clken low freezes every register including the pipeline.
module lr_consistency_check
    import sgm_lr_pkg::*;
#(
    parameter int WIDTH   = LR_WIDTH,
    parameter int FRAC    = LR_FRAC,
    parameter int DMAX    = LR_DMAX,
    parameter int INVALID = LR_INVALID
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clken,
    input  logic [COL_W-1:0]     width,
    input  logic [WIDTH-1:0]     thresh,
    lr_consistency_check_if.slave pix
);

    localparam int IDX_W = WIDTH - FRAC;

    logic             accept;
    logic [COL_W-1:0] col;
    logic [IDX_W-1:0] idx;
    logic             oob_in;
    logic [WIDTH-1:0] dr_sel;

    logic             v1;
    logic             oob1;
    logic [WIDTH-1:0] dl1;
    logic [WIDTH-1:0] dr1;

    logic [WIDTH:0]   diff;
    logic             bad;

    logic [WIDTH-1:0] disp_out_q;
    logic             reject_q;
    logic             valid_out_q;

    assign accept = clken & pix.valid_in;
    assign idx    = pix.disp_L[WIDTH-1:FRAC];
    // Matching column lies left of the row start, or beyond the history depth.
    assign oob_in = (32'(idx) > 32'(col)) | (32'(idx) >= 32'(DMAX));

    lr_disp_history #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .DMAX  (DMAX),
        .IDX_W (IDX_W)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .disp_R   (pix.disp_R),
        .idx      (idx),
        .dR_sel   (dr_sel)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            col  <= '0;
            v1   <= 1'b0;
            oob1 <= 1'b0;
            dl1  <= '0;
            dr1  <= '0;
        end else if (clken) begin
            v1 <= pix.valid_in;
            if (pix.valid_in) begin
                col  <= (col == width - COL_W'(1)) ? '0 : col + COL_W'(1);
                oob1 <= oob_in;
                dl1  <= pix.disp_L;
                dr1  <= dr_sel;
            end
        end
    end

    always_comb begin
        diff = '0;
        if (dl1 >= dr1) begin
            diff = {1'b0, dl1} - {1'b0, dr1};
        end else begin
            diff = {1'b0, dr1} - {1'b0, dl1};
        end
    end

    assign bad = oob1 | (diff > {1'b0, thresh});

    always_ff @(posedge clk) begin
        if (!rst) begin
            disp_out_q  <= '0;
            reject_q    <= 1'b0;
            valid_out_q <= 1'b0;
        end else if (clken) begin
            valid_out_q <= v1;
            if (v1) begin
                disp_out_q <= bad ? WIDTH'(INVALID) : dl1;
                reject_q   <= bad;
            end
        end
    end

    assign pix.disp_out  = disp_out_q;
    assign pix.reject    = reject_q;
    assign pix.valid_out = valid_out_q;

endmodule

// File: tb/tb_lr_consistency_check.sv
// Directed and randomized checks of lr_consistency_check against a row-buffer model.
module tb_lr_consistency_check;
    import sgm_lr_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clken = 1'b0;
    logic [10:0] width = 11'd8;
    logic [15:0] thresh = 16'd0;

    lr_consistency_check_if #(.WIDTH(16)) pix ();

    lr_consistency_check dut (
        .clk    (clk),
        .rst    (rst),
        .clken  (clken),
        .width  (width),
        .thresh (thresh),
        .pix    (pix.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int out;
        int rej;
        int cyc;
    } exp_t;

    exp_t expq[$];
    int   rowR[0:2047];
    int   col_m = 0;
    int   en_cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   n_pass = 0;
    int   n_vo = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the left pixel at column x matches the right pixel at x - int(dL) of the same row.
    task automatic model_accept(input int dl, input int dr, input int cyc);
        int x, idx, r, d, bad;
        exp_t e;
        x = col_m;
        rowR[x] = dr;
        idx = dl >> 4;
        bad = (idx > x || idx >= 128) ? 1 : 0;
        if (bad == 0) begin
            r = rowR[x - idx];
            d = (dl > r) ? dl - r : r - dl;
            bad = (d > int'(thresh)) ? 1 : 0;
        end
        e.out = (bad != 0) ? 0 : dl;
        e.rej = bad;
        e.cyc = cyc;
        expq.push_back(e);
        col_m = (x == int'(width) - 1) ? 0 : x + 1;
    endtask

    task automatic tick(input logic ce, input logic v, input int dl, input int dr);
        exp_t e;
        clken = ce;
        pix.valid_in = v;
        pix.disp_L = 16'(dl);
        pix.disp_R = 16'(dr);
        @(posedge clk);
        if (ce) begin
            if (v) model_accept(dl & 16'hFFFF, dr & 16'hFFFF, en_cyc);
            en_cyc++;
        end
        @(negedge clk);
        if (ce && pix.valid_out === 1'b1) begin
            n_vo++;
            if (expq.size() == 0) begin
                chk("spurious_valid", 32'(pix.valid_out), 32'd0);
            end else begin
                e = expq.pop_front();
                chk("disp_out", 32'(pix.disp_out), e.out);
                chk("reject", 32'(pix.reject), e.rej);
                chk("latency", en_cyc, e.cyc + 2);
                if (pix.reject === 1'b0) n_pass++;
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        clken = 1'b1;
        pix.valid_in = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_out", 32'(pix.valid_out), 32'd0);
        chk("rst_disp_out", 32'(pix.disp_out), 32'd0);
        chk("rst_reject", 32'(pix.reject), 32'd0);
        expq.delete();
        col_m = 0;
        rst = 1'b1;
    endtask

    task automatic drain();
        repeat (3) tick(1'b1, 1'b0, 0, 0);
    endtask

    task automatic finish_row();
        while (col_m != 0) tick(1'b1, 1'b1, $urandom_range(0, 255), $urandom_range(0, 255));
        drain();
    endtask

    initial begin
        int dlv, drv, imax;
        pix.valid_in = 1'b0;
        pix.disp_L = '0;
        pix.disp_R = '0;

        // Reset then idle: outputs stay at reset values.
        do_reset(3);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 0, 0);
            chk("idle_valid_out", 32'(pix.valid_out), 32'd0);
            chk("idle_disp_out", 32'(pix.disp_out), 32'd0);
            chk("idle_reject", 32'(pix.reject), 32'd0);
        end

        // dR = col*16, dL = 0x20, thresh 0x10: cols 3,4,5 within threshold.
        width = 11'd8; thresh = 16'h10; n_pass = 0;
        for (int x = 0; x < 8; x++) tick(1'b1, 1'b1, 32'h20, x * 16);
        drain();
        chk("ramp_pass_count", n_pass, 3);

        // Constant 0x30 on a 16-pixel row, exact match: columns 3..15 pass.
        width = 11'd16; thresh = 16'h0; n_pass = 0;
        for (int x = 0; x < 16; x++) tick(1'b1, 1'b1, 32'h30, 32'h30);
        drain();
        chk("const_pass_count", n_pass, 13);

        // Diff 0x15 exceeds thresh 0x10; diff 0x0F does not.
        width = 11'd8; thresh = 16'h10; n_pass = 0;
        for (int x = 0; x < 8; x++) tick(1'b1, 1'b1, 32'h30, 32'h45);
        drain();
        chk("over_thresh_pass_count", n_pass, 0);
        n_pass = 0;
        for (int x = 0; x < 8; x++) tick(1'b1, 1'b1, 32'h30, 32'h3F);
        drain();
        chk("under_thresh_pass_count", n_pass, 5);

        // Same row with random bubbles and clock-enable gaps.
        width = 11'd16; thresh = 16'h20; n_vo = 0;
        for (int x = 0; x < 16; x++) begin
            while ($urandom_range(0, 2) == 0) tick($urandom_range(0, 1) == 1, 1'b0, 32'h7777, 32'h7777);
            while ($urandom_range(0, 3) == 0) tick(1'b0, 1'b1, 32'h7777, 32'h7777);
            tick(1'b1, 1'b1, 32'h30 + x, 32'h28 + 2 * x);
        end
        drain();
        chk("gap_valid_count", n_vo, 16);

        // Row wrap with width 4: first pixel of row 2 with dL=0x10 is out of bounds.
        width = 11'd4; thresh = 16'hFFFF;
        for (int x = 0; x < 4; x++) tick(1'b1, 1'b1, 0, 32'h50);
        tick(1'b1, 1'b1, 32'h10, 32'h50);
        finish_row();

        // Reset mid-row: next beat is column 0 again.
        width = 11'd8;
        for (int x = 0; x < 3; x++) tick(1'b1, 1'b1, 0, 32'h40);
        do_reset(1);
        thresh = 16'hFFFF;
        tick(1'b1, 1'b1, 32'h10, 32'h40);
        tick(1'b1, 1'b1, 32'h10, 32'h40);
        finish_row();

        // width=1: every pixel is column 0.
        width = 11'd1; thresh = 16'h0;
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, (i % 2) * 16, (i % 2) * 16);
        drain();

        // Randomized rows, including idx near and beyond the history depth.
        for (int run = 0; run < 4; run++) begin
            width = (run == 3) ? 11'd200 : 11'($urandom_range(1, 40));
            thresh = 16'($urandom_range(0, 64));
            imax = (run == 3) ? 140 : 12;
            for (int i = 0; i < 500; i++) begin
                dlv = ($urandom_range(0, imax) << 4) | $urandom_range(0, 15);
                drv = ($urandom_range(0, 1) == 1) ? dlv + $urandom_range(0, 40) - 20 : $urandom_range(0, 65535);
                tick($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, dlv, drv & 16'hFFFF);
            end
            finish_row();
        end

        chk("drain_empty", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
